// File: rtl/nic_pkg.sv
// Shared constants for the buffered NIC: register map and status bit layout.
package nic_pkg;

  localparam logic [1:0] NIC_ADDR_IBUF  = 2'b00;
  localparam logic [1:0] NIC_ADDR_ISTAT = 2'b01;
  localparam logic [1:0] NIC_ADDR_OBUF  = 2'b10;
  localparam logic [1:0] NIC_ADDR_OSTAT = 2'b11;

  localparam int NIC_ST_NONEMPTY  = 0;
  localparam int NIC_ST_FULL      = 0;
  localparam int NIC_ST_OVF       = 1;
  localparam int NIC_ST_COUNT_LSB = 8;

endpackage

// File: rtl/nic_fifo.sv
// Synchronous FIFO used for both NIC channels; push into full
// and pop from empty are ignored internally.
module nic_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/nic_buffered.sv
// Buffered NIC: register-mapped processor port, valid/ready router port.
// NIC_STATUS_COUNT_EN exposes FIFO occupancy in the status words.
module nic_buffered
  import nic_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  input  logic              nicEN,
  input  logic              nicWrEn,
  output logic [DATA_W-1:0] d_out,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic              rd;
  logic              wr;
  logic              tx_push;
  logic              tx_pop;
  logic              tx_full;
  logic              tx_empty;
  logic [PTR_W:0]    tx_count;
  logic              rx_push;
  logic              rx_pop;
  logic              rx_full;
  logic              rx_empty;
  logic [PTR_W:0]    rx_count;
  logic [DATA_W-1:0] rx_head;
  logic              ovf;
  logic              ovf_set;
  logic              ovf_clr;
  logic [DATA_W-1:0] rx_stat;
  logic [DATA_W-1:0] tx_stat;

  assign rd = nicEN && !nicWrEn;
  assign wr = nicEN && nicWrEn;

  assign tx_push  = wr && (addr == NIC_ADDR_OBUF);
  assign ovf_set  = tx_push && tx_full;
  assign ovf_clr  = rd && (addr == NIC_ADDR_OSTAT);
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;

  // Hold rx_ready low during reset so no handshake completes on a flush edge
  assign rx_ready = !rst && !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rd && (addr == NIC_ADDR_IBUF);

  nic_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (d_in),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  nic_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_comb begin
    rx_stat = '0;
    tx_stat = '0;
    rx_stat[NIC_ST_NONEMPTY] = !rx_empty;
    tx_stat[NIC_ST_FULL]     = tx_full;
    tx_stat[NIC_ST_OVF]      = ovf;
`ifdef NIC_STATUS_COUNT_EN
    rx_stat[NIC_ST_COUNT_LSB +: PTR_W+1] = rx_count;
    tx_stat[NIC_ST_COUNT_LSB +: PTR_W+1] = tx_count;
`endif
  end

`ifndef NIC_STATUS_COUNT_EN
  logic cnt_unused;
  assign cnt_unused = ^{rx_count, tx_count};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out <= '0;
    end else if (rd) begin
      unique case (addr)
        NIC_ADDR_IBUF:  d_out <= rx_empty ? '0 : rx_head;
        NIC_ADDR_ISTAT: d_out <= rx_stat;
        NIC_ADDR_OBUF:  d_out <= '0;
        NIC_ADDR_OSTAT: d_out <= tx_stat;
      endcase
    end
  end

  // A drop in the same cycle as the clearing read wins
  always_ff @(posedge clk) begin
    if (rst)          ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_nic_buffered.sv
// Bench for nic_buffered: queue-based reference model, directed test plan,
// then randomized traffic with occasional resets.
module tb_nic_buffered;

  localparam int DW = 64;
  localparam int DEPTH = 4;
`ifdef NIC_STATUS_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    addr;
  logic [DW-1:0] d_in;
  logic          nicEN;
  logic          nicWrEn;
  logic [DW-1:0] d_out;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] tx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [DW-1:0] rx_data;

  nic_buffered #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .d_in(d_in),
    .nicEN(nicEN), .nicWrEn(nicWrEn), .d_out(d_out),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors = 0;

  logic [DW-1:0] txq[$];
  logic [DW-1:0] rxq[$];
  logic          m_ovf;
  logic [DW-1:0] m_dout;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] cnt_field(int n);
    logic [DW-1:0] v;
    v = 64'(n) << 8;
    return CNT_EN ? v : '0;
  endfunction

  // Apply one clock edge to the model using the inputs currently driven
  task automatic model_edge();
    bit tx_full, rx_full, tx_pop, rx_push, rx_pop, wr, rd;
    if (rst) begin
      txq.delete();
      rxq.delete();
      m_ovf = 1'b0;
      m_dout = '0;
      return;
    end
    tx_full = (txq.size() == DEPTH);
    rx_full = (rxq.size() == DEPTH);
    tx_pop  = (txq.size() > 0) && tx_ready;
    rx_push = rx_valid && !rx_full;
    wr = nicEN && nicWrEn;
    rd = nicEN && !nicWrEn;
    rx_pop = 1'b0;
    if (rd) begin
      case (addr)
        2'b00: begin
          if (rxq.size() > 0) begin
            m_dout = rxq[0];
            rx_pop = 1'b1;
          end else m_dout = '0;
        end
        2'b01: m_dout = cnt_field(rxq.size()) | 64'(rxq.size() > 0);
        2'b10: m_dout = '0;
        default: m_dout = cnt_field(txq.size()) | (64'(m_ovf) << 1) | 64'(tx_full);
      endcase
    end
    if (tx_pop) void'(txq.pop_front());
    if (rx_pop) void'(rxq.pop_front());
    if (rx_push) rxq.push_back(rx_data);
    if (wr && addr == 2'b10) begin
      if (tx_full) m_ovf = 1'b1;
      else txq.push_back(d_in);
    end else if (rd && addr == 2'b11) m_ovf = 1'b0;
  endtask

  // Per-cycle compare, taken at the falling edge before inputs change
  task automatic compare();
    chk("d_out", d_out, m_dout);
    chk("tx_valid", 64'(tx_valid), 64'(txq.size() > 0));
    chk("rx_ready", 64'(rx_ready), 64'(!rst && rxq.size() < DEPTH));
    if (txq.size() > 0) chk("tx_data", tx_data, txq[0]);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    nicEN = 0; nicWrEn = 0; cycle();
  endtask

  task automatic wr(logic [1:0] a, logic [DW-1:0] d);
    nicEN = 1; nicWrEn = 1; addr = a; d_in = d; cycle();
    nicEN = 0;
  endtask

  task automatic rd(logic [1:0] a);
    nicEN = 1; nicWrEn = 0; addr = a; cycle();
    nicEN = 0;
  endtask

  logic [DW-1:0] base;

  initial begin
    base = 64'h00ff_0000_ffff_fff0;
    rst = 1; addr = 0; d_in = 0; nicEN = 0; nicWrEn = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    cycle();
    cycle();
    chk("rst_dout", d_out, 64'h0);
    chk("rst_txv", 64'(tx_valid), 64'h0);
    rst = 0;
    idle();
    chk("rst_rxr", 64'(rx_ready), 64'h1);
    rd(2'b11);
    chk("ostat_rst", d_out, 64'h0);

    for (int i = 0; i < 4; i++) wr(2'b10, base + 64'(i));
    rd(2'b11);
    chk("ostat_full", d_out, cnt_field(4) | 64'h1);
    wr(2'b10, base + 64'd4);
    rd(2'b11);
    chk("ostat_ovf", d_out, cnt_field(4) | 64'h3);
    rd(2'b11);
    chk("ostat_ovfclr", d_out, cnt_field(4) | 64'h1);

    for (int i = 0; i < 4; i++) begin
      chk("txseq", tx_data, base + 64'(i));
      tx_ready = 1;
      cycle();
    end
    chk("tx_drained", 64'(tx_valid), 64'h0);
    tx_ready = 0;

    rx_valid = 1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 64'hA000 + 64'(i);
      cycle();
    end
    chk("rx_full", 64'(rx_ready), 64'h0);
    rx_valid = 0;
    for (int i = 0; i < 5; i++) begin
      rd(2'b00);
      chk("rxseq", d_out, (i < 4) ? 64'hA000 + 64'(i) : 64'h0);
    end

    wr(2'b10, 64'h11);
    wr(2'b10, 64'h22);
    tx_ready = 1;
    wr(2'b10, 64'h33);
    tx_ready = 0;
    rd(2'b11);
    chk("simul_cnt", d_out, cnt_field(2));
    chk("simul_head", tx_data, 64'h22);
    wr(2'b10, 64'h44);
    wr(2'b10, 64'h55);
    tx_ready = 1;
    wr(2'b10, 64'h66);
    tx_ready = 0;
    rd(2'b11);
    chk("full_pop", d_out, cnt_field(3) | 64'h2);

    rx_valid = 1; rx_data = 64'hBEEF;
    cycle();
    cycle();
    rx_valid = 0;
    rst = 1;
    cycle();
    rst = 0;
    chk("mid_rst_txv", 64'(tx_valid), 64'h0);
    rd(2'b01);
    chk("mid_rst_ist", d_out, 64'h0);

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      addr = 2'($urandom_range(0, 3));
      d_in = {$urandom, $urandom};
      nicEN = ($urandom_range(0, 2) != 0);
      nicWrEn = $urandom_range(0, 1) != 0;
      tx_ready = ($urandom_range(0, 3) == 0);
      rx_valid = $urandom_range(0, 1) != 0;
      rx_data = {$urandom, $urandom};
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/nic_buffered.md
# nic_buffered

Parametrised network interface controller placed between one processor core and one router port of the interconnect. Next generation of the single-entry NIC: the output (processor→network) and input (network→processor) channels are DEPTH-deep FIFOs, status registers report occupancy, and dropped writes are flagged. The processor side keeps the 2-bit address register interface; the router side uses valid/ready handshakes.

## Interface
- DATA_W, 64, packet width; bit DATA_W-1 is VC, bit DATA_W-2 is direction, payload unrestricted
- DEPTH, 4, entries per FIFO; power of two, ≥2
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- addr  in  2  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status
- d_in  in  DATA_W  processor write data
- nicEN  in  1  register access enable
- nicWrEn  in  1  1 = write, 0 = read (qualified by nicEN)
- d_out  out  DATA_W  registered read data
- tx_valid  out  1  output FIFO non-empty
- tx_ready  in  1  router accepts tx_data
- tx_data  out  DATA_W  output FIFO head
- rx_valid  in  1  router presents rx_data
- rx_ready  out  1  input FIFO not full
- rx_data  in  DATA_W  packet from router

## Operation
- Write addr 10 with nicEN&nicWrEn: push d_in to output FIFO if not full at cycle start; if full, write dropped, sticky ovf set.
- Writes to 00/01/11 ignored. Reads of 10 return 0.
- Read addr 00: if input FIFO non-empty, d_out ← head and pop same edge; if empty, d_out ← 0, no pop.
- Read addr 01: d_out ← {0…, rx_count field, nonempty bit0}.
- Read addr 11: d_out ← {0…, tx_count field, ovf bit1, full bit0}; clears ovf. Set in same cycle as clear: set wins (ovf stays 1).
- d_out updates only on reads (nicEN&!nicWrEn); otherwise holds.
- Router side: tx pop on tx_valid&tx_ready; rx push on rx_valid&rx_ready.
- rx_ready = !rx_full (no push into full FIFO even if processor pops that cycle). Output FIFO write uses full at cycle start; simultaneous tx pop does not rescue it.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both performed.
- Pointers PTR_W=$clog2(DEPTH) bits, wrap modulo DEPTH; count is PTR_W+1 bits (0..DEPTH).
- FIFO contents preserved in order; no reordering by VC.

## Timing
- Reset values: d_out=0, tx_valid=0, rx_ready=1 the cycle after rst deasserts (and while rst=1: rx_ready=0), ovf=0, both FIFOs empty; tx_data don't-care while tx_valid=0.
- Read latency 1 cycle: request at edge N, d_out valid after edge N.
- Write-to-tx_valid latency 1 cycle (push at edge N, tx_valid high after N).
- rx push at edge N visible as nonempty in status read issued at N+1.
- rx_ready, tx_valid, tx_data are pure functions of registered FIFO state (no combinational path from tx_ready/rx_valid).
- rst mid-operation: FIFOs flushed, in-flight handshakes discarded, same edge.

## Configuration
- NIC_STATUS_COUNT_EN defined: status reads carry occupancy count in bits [8+PTR_W:8] (rx_count at 01, tx_count at 11).
- Undefined: those bits read 0; only full/nonempty/ovf bits present. Count registers may still exist internally.

## Structure
- Package nic_pkg: address constants NIC_ADDR_IBUF=2'b00, NIC_ADDR_ISTAT=2'b01, NIC_ADDR_OBUF=2'b10, NIC_ADDR_OSTAT=2'b11; status bit indices (NONEMPTY=0, FULL=0, OVF=1, COUNT_LSB=8).
- Sub-module nic_fifo (sync FIFO, DATA_W/DEPTH parameters, push/pop/full/empty/count), instantiated twice; nic_buffered holds register decode, d_out register, ovf flag.

## Test plan
- Reset: rst=1 two cycles → d_out=0, tx_valid=0, ovf=0; status 11 reads 0.
- DEPTH=4, tx_ready=0, write 64'h00ff_0000_ffff_fff0..fff3 to addr 10 → status 11 full=1, count=4 (with macro); fifth write 64'h…fff4 dropped, ovf=1; second status read ovf=0.
- Then tx_ready=1 → tx_data sequence fff0,fff1,fff2,fff3 on four consecutive cycles, tx_valid low after.
- rx_valid=1 with 5 packets, no reads → rx_ready drops after 4 accepted; addr 00 reads return packets in order, d_out=0 on fifth read (empty).
- Simultaneous: output FIFO holding 2, write + tx pop same cycle → count stays 2, order preserved; full FIFO write + pop same cycle → write dropped, ovf=1.
- rst asserted with both FIFOs half full → next cycle tx_valid=0, status 01 nonempty=0.
